// File: rtl/lcd_text_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_text_arbiter
//  Purpose  : 32-character shadow buffer for an LCD1602 driver, shared between
//             NREQ writers through a round-robin grant. Pulses frame_upd when
//             a session that wrote at least one character ends.
//  Revision : 1.0  initial release
// ============================================================================
module lcd_text_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   rel,
  input  logic [NREQ-1:0]   wr,
  input  logic [5*NREQ-1:0] wr_addr,
  input  logic [8*NREQ-1:0] wr_char,
  output logic [NREQ-1:0]   gnt,
  output logic [255:0]      disp,
  output logic              busy,
  output logic              frame_upd
);

  localparam int IW = (NREQ > 2) ? 2 : 1;
  // The counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wflag_q, wflag_d;
  logic            fupd_q, fupd_d;
  logic [7:0]      buf_q [32];

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic            wr_g;
  logic [4:0]      addr_g;
  logic [7:0]      char_g;
  logic            release_g;

  // Round-robin pick: first requesting index at or above rr_q, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_found && req[(int'(rr_q) + i) % NREQ]) begin
        pick_found = 1'b1;
        pick_idx   = IW'((int'(rr_q) + i) % NREQ);
      end
    end
  end

  // Only the granted requester's strobe, address and data are ever looked at.
  assign wr_g      = (state_q == S_GRANT) && wr[gidx_q];
  assign addr_g    = wr_addr[5*gidx_q +: 5];
  assign char_g    = wr_char[8*gidx_q +: 8];
  // A write in the last idle cycle keeps the grant alive, hence the !wr_g term.
  assign release_g = rel[gidx_q] | ~req[gidx_q] | ((cnt_q == CNT_LAST) && !wr_g);

  // Next-state logic for the grant FSM, counter, write flag and update pulse.
  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    wflag_d = wflag_q;
    fupd_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d = S_GRANT;
          gidx_d  = pick_idx;
          gnt_d   = NREQ'(1) << pick_idx;
          cnt_d   = '0;
          wflag_d = 1'b0;
        end
      end
      S_GRANT: begin
        if (wr_g) begin
          wflag_d = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (release_g) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          rr_d    = (gidx_q == IDX_LAST) ? '0 : gidx_q + 1'b1;
          fupd_d  = wflag_q | wr_g;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gidx_q  <= '0;
      gnt_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      wflag_q <= 1'b0;
      fupd_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      wflag_q <= wflag_d;
      fupd_q  <= fupd_d;
    end
  end

  // Character buffer: spaces on reset, granted writes land one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 32; k++) buf_q[k] <= 8'h20;
    end else if (wr_g) begin
      buf_q[addr_g] <= char_g;
    end
  end

  generate
    for (genvar k = 0; k < 32; k++) begin : g_disp
      assign disp[8*k +: 8] = buf_q[k];
    end
  endgenerate

  assign gnt       = gnt_q;
  assign busy      = (state_q == S_GRANT);
  assign frame_upd = fupd_q;

endmodule
`default_nettype wire
